// File: rtl/smol_pc.sv
// -----------------------------------------------------------------------------
// smol_pc -- program-counter register for the smolCore fetch stage.
//
// On every rising clock edge outside reset, the block loads next_pc as given.
// It also drives status derived from that register for fetch and debug.
//
// Parameters
//   XLEN          width of pc / next_pc and the address outputs
//   RESET_VECTOR  value of pc (and prev_pc) while and after reset
//   CNT_W         width of the load counter
//
// Ports
//   clk            in   system clock, all state updates on its rising edge
//   rst            in   asynchronous active-high reset
//   next_pc        in   address captured on the next rising edge
//   pc             out  current program counter (registered)
//   pc_plus4       out  pc + 4, combinational, wraps modulo 2^XLEN
//   prev_pc        out  value pc held before the most recent load
//   pc_misaligned  out  combinational, high when pc[1:0] != 2'b00
//   pc_valid       out  high once at least one load has happened since reset
//   load_count     out  number of loads since reset, wraps after all-ones
// -----------------------------------------------------------------------------
module smol_pc #(
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
  parameter int                CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  next_pc,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  output logic [XLEN-1:0]  prev_pc,
  output logic             pc_misaligned,
  output logic             pc_valid,
  output logic [CNT_W-1:0] load_count
);

  logic [XLEN-1:0]  pc_q,      pc_d;
  logic [XLEN-1:0]  prev_pc_q, prev_pc_d;
  logic             valid_q,   valid_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  // There is no enable or stall: every non-reset edge is a load. next_pc is
  // taken verbatim, so misaligned (or unknown) addresses pass straight through.
  always_comb begin
    pc_d      = next_pc;
    prev_pc_d = pc_q;
    valid_d   = 1'b1;
    cnt_d     = cnt_q + CNT_W'(1);
  end

  // An edge that arrives while rst is still high is a reset cycle, so the
  // first load happens on the first edge after rst has gone low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_VECTOR;
      prev_pc_q <= RESET_VECTOR;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      prev_pc_q <= prev_pc_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pc            = pc_q;
  assign prev_pc       = prev_pc_q;
  assign pc_valid      = valid_q;
  assign load_count    = cnt_q;
  // The carry out of the top bit is dropped on purpose; fetch only needs the
  // wrapped fall-through address.
  assign pc_plus4      = pc_q + XLEN'(4);
  assign pc_misaligned = |pc_q[1:0];

endmodule

// File: tb/tb_smol_pc.sv
// -----------------------------------------------------------------------------
// tb_smol_pc -- self-checking bench for smol_pc.
//
// Two instances share the stimulus: u_dut uses the default parameters, and
// u_dut_p uses RESET_VECTOR=32'h1000 with a 4-bit counter, so that
// counter wrap-around can be reached with a few loads.
// The reference model keeps the list of addresses loaded since the last reset.
// Every output is derived from that list with plain arithmetic. A
// compare process checks both instances against the model on each falling
// edge. Directed checks with hand-computed literals follow each step.
// -----------------------------------------------------------------------------
module tb_smol_pc;

  localparam logic [31:0] RV_P = 32'h0000_1000;
  localparam int          CW_P = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] next_pc;

  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  logic [31:0] pc, pc_plus4, prev_pc;
  logic        pc_misaligned, pc_valid;
  logic [31:0] load_count;

  logic [31:0] pc_p, pc_plus4_p, prev_pc_p;
  logic        pc_misaligned_p, pc_valid_p;
  logic [CW_P-1:0] load_count_p;

  smol_pc u_dut (
    .clk(clk), .rst(rst), .next_pc(next_pc),
    .pc(pc), .pc_plus4(pc_plus4), .prev_pc(prev_pc),
    .pc_misaligned(pc_misaligned), .pc_valid(pc_valid),
    .load_count(load_count)
  );

  smol_pc #(.XLEN(32), .RESET_VECTOR(RV_P), .CNT_W(CW_P)) u_dut_p (
    .clk(clk), .rst(rst), .next_pc(next_pc),
    .pc(pc_p), .pc_plus4(pc_plus4_p), .prev_pc(prev_pc_p),
    .pc_misaligned(pc_misaligned_p), .pc_valid(pc_valid_p),
    .load_count(load_count_p)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Addresses loaded since the last reset, oldest first.
  logic [31:0] exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) exp_q.delete();
    else     exp_q.push_back(next_pc);
  end

  function automatic logic [31:0] m_pc(input logic [31:0] rv);
    return (exp_q.size() == 0) ? rv : exp_q[exp_q.size()-1];
  endfunction

  function automatic logic [31:0] m_prev(input logic [31:0] rv);
    return (exp_q.size() < 2) ? rv : exp_q[exp_q.size()-2];
  endfunction

  function automatic logic [31:0] m_cnt(input int w);
    longint unsigned n;
    n = longint'(exp_q.size());
    return 32'(n % (64'd1 << w));
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [31:0] p, pp;
    p  = m_pc(32'h0);
    pp = m_pc(RV_P);
    check("pc",            pc,                    p);
    check("pc_plus4",      pc_plus4,              p + 32'd4);
    check("prev_pc",       prev_pc,               m_prev(32'h0));
    check("pc_misaligned", 32'(pc_misaligned),    32'((p % 4) != 0));
    check("pc_valid",      32'(pc_valid),         32'(exp_q.size() > 0));
    check("load_count",    load_count,            m_cnt(32));
    check("p.pc",          pc_p,                  pp);
    check("p.pc_plus4",    pc_plus4_p,            pp + 32'd4);
    check("p.prev_pc",     prev_pc_p,             m_prev(RV_P));
    check("p.pc_valid",    32'(pc_valid_p),       32'(exp_q.size() > 0));
    check("p.load_count",  32'(load_count_p),     m_cnt(CW_P));
  end

  // ---------------- driver ----------------
  // Present v, then return 1 time unit after the edge that loads it.
  task automatic step(input logic [31:0] v);
    next_pc = v;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst     = 1'b1;
    next_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    // reset state, literal expectations
    check("rst pc",        pc, 32'h0);
    check("rst prev_pc",   prev_pc, 32'h0);
    check("rst pc_valid",  32'(pc_valid), 32'h0);
    check("rst load_cnt",  load_count, 32'h0);
    check("rst pc_plus4",  pc_plus4, 32'h4);
    check("rst misalign",  32'(pc_misaligned), 32'h0);
    check("rst p.pc",      pc_p, 32'h1000);
    check("rst p.plus4",   pc_plus4_p, 32'h1004);

    rst = 1'b0;

    // sequential loads
    step(32'h0000_000A);
    check("ld1 pc",       pc, 32'hA);
    check("ld1 misalign", 32'(pc_misaligned), 32'h1);
    check("ld1 plus4",    pc_plus4, 32'hE);
    check("ld1 valid",    32'(pc_valid), 32'h1);
    check("ld1 cnt",      load_count, 32'd1);
    step(32'h0000_000E);
    check("ld2 pc",       pc, 32'hE);
    check("ld2 prev",     prev_pc, 32'hA);
    check("ld2 cnt",      load_count, 32'd2);
    step(32'h1234_5678);
    check("ld3 plus4",    pc_plus4, 32'h1234_567C);
    check("ld3 misalign", 32'(pc_misaligned), 32'h0);
    check("ld3 cnt",      load_count, 32'd3);
    step(32'h0000_0000);
    check("ld4 pc",       pc, 32'h0);
    check("ld4 prev",     prev_pc, 32'h1234_5678);
    check("ld4 cnt",      load_count, 32'd4);

    // next_pc wiggles between edges; only the value at the edge counts
    next_pc = 32'h100;
    #3 next_pc = 32'h200;
    #3 next_pc = 32'h100;
    @(posedge clk);
    #1;
    check("mid pc",  pc, 32'h100);
    check("mid cnt", load_count, 32'd5);

    // fall-through address wraps
    step(32'hFFFF_FFFC);
    check("wrap plus4", pc_plus4, 32'h0);
    check("wrap misal", 32'(pc_misaligned), 32'h0);

    // 16 loads in total take the 4-bit counter back to 0
    for (int i = 0; i < 9; i++) step(32'(i * 8));
    step(32'h1234_5678);
    check("cnt16 p.cnt", 32'(load_count_p), 32'h0);
    check("cnt16 cnt",   load_count, 32'd16);

    // asynchronous reset in the middle of a cycle
    #2 rst = 1'b1;
    #1;
    check("arst pc",    pc, 32'h0);
    check("arst prev",  prev_pc, 32'h0);
    check("arst valid", 32'(pc_valid), 32'h0);
    check("arst cnt",   load_count, 32'h0);
    check("arst p.pc",  pc_p, 32'h1000);

    // release exactly on an edge: that edge is still a reset cycle.
    // The nonblocking update lets the flops sample rst high on this edge.
    next_pc = 32'h40;
    @(posedge clk);
    rst <= 1'b0;
    #1;
    check("rel pc",  pc, 32'h0);
    check("rel cnt", load_count, 32'h0);
    @(posedge clk);
    #1;
    check("rel2 pc",    pc, 32'h40);
    check("rel2 prev",  prev_pc, 32'h0);
    check("rel2 cnt",   load_count, 32'd1);
    check("rel2 p.prv", prev_pc_p, 32'h1000);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a stuck run.
  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
